// File: rtl/fdtd_stream_engine.sv
// -----------------------------------------------------------------------------
// fdtd_stream_engine
//
// Streaming 1-D FDTD field update engine. One pass walks N cells in order and
// produces the updated field for each cell:
//   Ez pass (mode_i=1): out[m] = ceze*Ez[m] + cezhy*(Hy[m]-Hy[m-1]) - [m==src]*cezj*Jz
//   Hy pass (mode_i=0): out[m] = chyh*Hy[m] + chyez*(Ez[m+1]-Ez[m])
// All operands are signed Q-format with FRAC_BITS fractional bits.
//
// Ports
//   CLK, RST_N                 clock, synchronous active-low reset
//   start_i                    pass start (sampled in IDLE only)
//   mode_i, size_i, src_idx_i  pass type, cell count N, source cell (latched at start)
//   coef_self_i/curl_i/src_i   Hy pass: chyh, chyez, unused; Ez pass: ceze, cezhy, cezj
//   jz_i                       source current Jz
//   in_valid_i/in_ready_o      input beat handshake; beat m carries
//   in_self_i, in_other_i      updated field [m] and other field [m]
//   out_valid_o/out_ready_i    result handshake
//   out_data_o                 updated field, cell order
//   busy_o, done_o             pass active, one-cycle end-of-pass pulse
//   steps_done_o, step_cnt_o   sticky TIME_STEPS reached, completed Ez passes
//   sat_o                      sticky saturation flag
//
// Build option: define FDTD_SATURATE_EN to clamp out-of-range results and
// report them on sat_o; otherwise results wrap and sat_o is tied low.
// -----------------------------------------------------------------------------
module fdtd_stream_engine #(
   parameter int FDTD_DATA_WIDTH = 32,
   parameter int FRAC_BITS       = 16,
   parameter int REG_SIZE_WIDTH  = 16,
   parameter int TIME_STEPS      = 50
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       start_i,
   input  logic                       mode_i,
   input  logic [REG_SIZE_WIDTH-1:0]  size_i,
   input  logic [REG_SIZE_WIDTH-1:0]  src_idx_i,
   input  logic [FDTD_DATA_WIDTH-1:0] coef_self_i,
   input  logic [FDTD_DATA_WIDTH-1:0] coef_curl_i,
   input  logic [FDTD_DATA_WIDTH-1:0] coef_src_i,
   input  logic [FDTD_DATA_WIDTH-1:0] jz_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [FDTD_DATA_WIDTH-1:0] in_self_i,
   input  logic [FDTD_DATA_WIDTH-1:0] in_other_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [FDTD_DATA_WIDTH-1:0] out_data_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       steps_done_o,
   output logic                       sat_o,
   output logic [REG_SIZE_WIDTH-1:0]  step_cnt_o
);

   localparam int W  = FDTD_DATA_WIDTH;
   localparam int DW = FDTD_DATA_WIDTH + 1;
   localparam int SW = FDTD_DATA_WIDTH + 2;
   localparam int PW = 2 * FDTD_DATA_WIDTH;
   localparam logic [REG_SIZE_WIDTH-1:0] STEP_LIMIT = REG_SIZE_WIDTH'(TIME_STEPS);
   localparam logic [REG_SIZE_WIDTH-1:0] ONE        = REG_SIZE_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // pass context
   logic                      mode_q;
   logic [REG_SIZE_WIDTH-1:0] size_q;
   logic [REG_SIZE_WIDTH-1:0] src_q;
   logic [REG_SIZE_WIDTH-1:0] beat_q;
   logic signed [W-1:0]       held_self_q;
   logic signed [W-1:0]       held_other_q;
   logic                      flush_issued_q;

   // handshake / control
   logic stage_en;
   logic in_hs;
   logic out_hs;
   logic last_beat;
   logic flush_fire;
   logic issue;
   logic src_hit;

   // stage 1 (multiply)
   logic signed [W-1:0]  coef_self_s, coef_curl_s, coef_src_s, jz_s;
   logic signed [W-1:0]  self_op;
   logic signed [W-1:0]  other_next;
   logic signed [DW-1:0] curl_diff;
   logic signed [PW-1:0] p_self, p_curl, p_src;
   logic                 s1_valid_q;
   logic signed [SW-1:0] s1_self_q, s1_curl_q, s1_src_q;

   // stage 2 (add / reduce)
   logic signed [SW-1:0] sum;
   logic [W-1:0]         reduced;
   logic                 clamp;

   logic [REG_SIZE_WIDTH-1:0] step_q;
   logic                      steps_done_q;

   // Product scaled back to Q-format; only the low SW bits take part in the sum.
   function automatic logic signed [SW-1:0] scale(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] s;
      s = p >>> FRAC_BITS;
      return s[SW-1:0];
   endfunction

   assign stage_en   = !out_valid_o || out_ready_i;
   assign in_ready_o = (state_q == S_RUN) && stage_en;
   assign in_hs      = in_valid_i && in_ready_o;
   assign out_hs     = out_valid_o && out_ready_i;
   assign last_beat  = (beat_q == (size_q - ONE));
   assign flush_fire = (state_q == S_FLUSH) && !flush_issued_q && stage_en;

   // Ez cells are complete on their own beat; Hy cell m needs beat m+1 (or the
   // flush slot for the last cell), so the first Hy beat issues nothing.
   assign issue   = (in_hs && (mode_q || (beat_q != '0))) || flush_fire;
   assign src_hit = mode_q && (beat_q == src_q);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done_o  = 1'b0;
      busy_o  = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               state_d = (size_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (in_hs && last_beat) begin
               state_d = mode_q ? S_DONE : S_FLUSH;
            end
         end
         S_FLUSH: begin
            // The flush entry is the youngest; once it leaves and stage 1 is
            // empty, the Hy pass has delivered every result.
            if (out_hs && flush_issued_q && !s1_valid_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- operands
   always_comb begin
      coef_self_s = coef_self_i;
      coef_curl_s = coef_curl_i;
      coef_src_s  = coef_src_i;
      jz_s        = jz_i;
      // Ez: self is this beat's Ez; Hy: self is the held Hy of the previous beat.
      self_op     = mode_q ? signed'(in_self_i) : held_self_q;
      // Ez[N] is zero for the final Hy cell computed in FLUSH.
      other_next  = (state_q == S_FLUSH) ? '0 : signed'(in_other_i);
      curl_diff   = DW'(other_next) - DW'(held_other_q);
      p_self      = PW'(coef_self_s) * PW'(self_op);
      p_curl      = PW'(coef_curl_s) * PW'(curl_diff);
      p_src       = PW'(coef_src_s) * PW'(jz_s);
   end

   // ---------------------------------------------------------------- reduce
   always_comb begin
      sum = s1_self_q + s1_curl_q - s1_src_q;
`ifdef FDTD_SATURATE_EN
      clamp   = (sum[SW-1:W-1] != '0) && (sum[SW-1:W-1] != '1);
      reduced = sum[W-1:0];
      if (clamp) begin
         reduced = sum[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
`else
      clamp   = 1'b0;
      reduced = sum[W-1:0];
`endif
   end

`ifndef FDTD_SATURATE_EN
   logic unused_sum_hi;
   assign unused_sum_hi = ^{sum[SW-1:W], clamp};
`endif

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         mode_q         <= 1'b0;
         size_q         <= '0;
         src_q          <= '0;
         beat_q         <= '0;
         held_self_q    <= '0;
         held_other_q   <= '0;
         flush_issued_q <= 1'b0;
         s1_valid_q     <= 1'b0;
         s1_self_q      <= '0;
         s1_curl_q      <= '0;
         s1_src_q       <= '0;
         out_valid_o    <= 1'b0;
         out_data_o     <= '0;
      end else begin
         if ((state_q == S_IDLE) && start_i) begin
            mode_q         <= mode_i;
            size_q         <= size_i;
            src_q          <= src_idx_i;
            beat_q         <= '0;
            held_self_q    <= '0;
            held_other_q   <= '0;
            flush_issued_q <= 1'b0;
         end
         if (in_hs) begin
            beat_q       <= beat_q + ONE;
            held_self_q  <= in_self_i;
            held_other_q <= in_other_i;
         end
         if (flush_fire) begin
            flush_issued_q <= 1'b1;
         end
         if (stage_en) begin
            s1_valid_q  <= issue;
            s1_self_q   <= scale(p_self);
            s1_curl_q   <= scale(p_curl);
            s1_src_q    <= src_hit ? scale(p_src) : '0;
            out_valid_o <= s1_valid_q;
            if (s1_valid_q) begin
               out_data_o <= reduced;
            end
         end
      end
   end

`ifdef FDTD_SATURATE_EN
   logic sat_q;
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sat_q <= 1'b0;
      end else if (stage_en && s1_valid_q && clamp) begin
         sat_q <= 1'b1;
      end
   end
   assign sat_o = sat_q;
`else
   assign sat_o = 1'b0;
`endif

   // ---------------------------------------------------------------- step count
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         step_q       <= '0;
         steps_done_q <= 1'b0;
      end else if ((state_q == S_DONE) && mode_q && (step_q < STEP_LIMIT)) begin
         step_q <= step_q + ONE;
         if ((step_q + ONE) == STEP_LIMIT) begin
            steps_done_q <= 1'b1;
         end
      end
   end

   assign step_cnt_o   = step_q;
   assign steps_done_o = steps_done_q;

endmodule

// File: doc/fdtd_stream_engine.md
FDTD_STREAM_ENGINE -- requirements
Module: fdtd_stream_engine

Interface
REQ-001 SHALL have parameter FDTD_DATA_WIDTH, default 32, field/coefficient width (signed).
REQ-002 SHALL have parameter FRAC_BITS, default 16, fractional bits of all Q-format operands.
REQ-003 SHALL have parameter REG_SIZE_WIDTH, default 16, width of cell count and indices.
REQ-004 SHALL have parameter TIME_STEPS, default 50, number of Ez passes after which the run is complete.
REQ-005 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start_i  input  1  one-cycle pass start, sampled only in IDLE.
REQ-008 SHALL have port mode_i  input  1  0 = Hy pass, 1 = Ez pass, latched at start.
REQ-009 SHALL have port size_i  input  REG_SIZE_WIDTH  cell count N, latched at start.
REQ-010 SHALL have port src_idx_i  input  REG_SIZE_WIDTH  source cell index, latched at start.
REQ-011 SHALL have port coef_self_i, coef_curl_i, coef_src_i  input  FDTD_DATA_WIDTH each.
- Hy pass: chyh, chyez, unused.
- Ez pass: ceze, cezhy, cezj.
REQ-012 SHALL have port jz_i  input  FDTD_DATA_WIDTH  source current Jz.
REQ-013 SHALL have ports in_valid_i/in_ready_o  input/output  1  input beat handshake.
REQ-014 SHALL have ports in_self_i, in_other_i  input  FDTD_DATA_WIDTH  beat m: updated field [m], other field [m].
REQ-015 SHALL have ports out_valid_o/out_ready_i  output/input  1  result handshake.
REQ-016 SHALL have port out_data_o  output  FDTD_DATA_WIDTH  updated field value, cell order.
REQ-017 SHALL have ports busy_o, done_o, steps_done_o, sat_o  output  1 each.
- busy_o: pass active.
- done_o: one-cycle end-of-pass pulse.
- steps_done_o: sticky, TIME_STEPS reached.
- sat_o: sticky saturation flag.
REQ-018 SHALL have port step_cnt_o  output  REG_SIZE_WIDTH  completed Ez passes.

Function
REQ-019 SHALL implement FSM IDLE -> RUN on start_i; RUN -> FLUSH (Hy pass) or DONE (Ez pass) when beat N-1 is accepted; FLUSH -> DONE on last output handshake; DONE -> IDLE after one cycle with done_o=1.
REQ-020 SHALL, in an Ez pass, output out[m] = ceze*Ez[m] + cezhy*(Hy[m]-Hy[m-1]), with Hy[-1]=0, and subtract cezj*Jz at m==src_idx.
REQ-021 SHALL, in a Hy pass, output out[m] = chyh*Hy[m] + chyez*(Ez[m+1]-Ez[m]), with Ez[N]=0.
- Cell m is computed when beat m+1 arrives; cell N-1 is computed in FLUSH.
REQ-022 SHALL clear the held neighbour register to 0 at each start.
REQ-023 SHALL form each product at 2*FDTD_DATA_WIDTH bits and arithmetic-shift it right by FRAC_BITS.
REQ-024 SHALL sum the terms at FDTD_DATA_WIDTH+2 bits and then reduce the sum to FDTD_DATA_WIDTH bits per REQ-035/036.
REQ-025 SHALL use a 2-stage pipeline (multiply, add/reduce).
- Ez pass, no stall: out_valid_o rises 2 cycles after the beat handshake.
REQ-026 SHALL advance all pipeline stages only when !out_valid_o || out_ready_i.
- in_ready_o = RUN && stage enable.
- No beat is lost or duplicated under any backpressure pattern.
REQ-027 SHALL hold out_data_o stable while out_valid_o && !out_ready_i.
REQ-028 SHALL ignore start_i outside IDLE.
REQ-029 SHALL, on start with size_i==0, go directly to DONE with no beats and no outputs.
REQ-030 SHALL increment step_cnt_o at the DONE of each Ez pass while step_cnt_o < TIME_STEPS.
- steps_done_o sets when step_cnt_o reaches TIME_STEPS; the counter then holds.
REQ-031 SHALL hold busy_o=1 in RUN, FLUSH and DONE.

Reset
REQ-032 SHALL, when RST_N=0 at a clock edge, force the FSM to IDLE and flush the pipeline, including mid-pass; partial results are discarded.
REQ-033 SHALL drive these reset values: out_valid_o=0, out_data_o=0, in_ready_o=0, busy_o=0, done_o=0, step_cnt_o=0, steps_done_o=0, sat_o=0.

Configuration
REQ-034 SHALL use macro FDTD_SATURATE_EN to select the width reduction of REQ-024.
REQ-035 SHALL, with FDTD_SATURATE_EN defined, clamp out-of-range sums to 0x7FFF..F / 0x800..0 and set sat_o.
REQ-036 SHALL, without FDTD_SATURATE_EN, truncate (two's-complement wrap) out-of-range sums and tie sat_o to 0.

Verification
REQ-037 SHALL cover: Ez pass, N=3, ceze=0x10000, cezhy=0x8000, Hy=[2,4,8]<<16, Ez=0 -> out=[1,1,2]<<16, done_o one cycle after the last handshake, step_cnt_o=1.
REQ-038 SHALL cover: Hy pass, N=3, chyh=chyez=0x10000, Hy=0, Ez=[1,3,6]<<16 -> out=[2,3,-6]<<16, third result emitted from FLUSH, step_cnt_o unchanged.
REQ-039 SHALL cover: Ez pass, N=2, src_idx=1, ceze=cezj=0x10000, Jz=5<<16, other inputs 0 -> out=[0,-5<<16].
REQ-040 SHALL cover: Ez=0x7FFF0000, ceze=cezhy=0x10000, Hy diff=0x10000 -> 0x7FFFFFFF with sat_o=1 (macro on); 0x80000000 with sat_o=0 (macro off).
REQ-041 SHALL cover: out_ready_i low for 5 cycles mid-pass -> in_ready_o drops, all N results exact and in order; RST_N low mid-pass -> all outputs at reset values next cycle.
REQ-042 SHALL cover: size_i=0 Ez pass -> done_o pulse, no out_valid_o; TIME_STEPS=2 and three Ez passes -> step_cnt_o=2, steps_done_o=1.
